// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU and branch resolution, plus a 32-iteration
// shift-add multiplier that stalls decode while it runs.
module execute_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [11:0] pc,
  input  logic [4:0]  opcode,
  input  logic [4:0]  aluop,
  input  logic [4:0]  shamt,
  input  logic [31:0] num_a,
  input  logic [31:0] num_b,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        en,
  input  logic        mwen,
  input  logic        lw,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_en,
  output logic        out_mwen,
  output logic        out_lw,
  output logic        out_ovf,
  output logic        branch_taken,
  output logic [11:0] branch_target
);

  localparam int DATA_W = 32;
  localparam logic [4:0] LAST = 5'(MUL_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [4:0]        mrd_q, mrd_d;
  logic              men_q, men_d, mmwen_q, mmwen_d, mlw_q, mlw_d;

  logic              valid_q, valid_d, en_q, en_d, mwen_q, mwen_d, lw_q, lw_d;
  logic              ovf_q, ovf_d, br_q, br_d;
  logic [DATA_W-1:0] result_q, result_d, sdata_q, sdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [11:0]       tgt_q, tgt_d;

  logic signed [DATA_W-1:0] a_s, b_s, sd_s, sum_s, diff_s;
  logic [DATA_W-1:0] alu_res, acc_sum;
  logic              alu_ovf, br_take, is_mul;

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a, b, s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a, b, d);
    return (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
  endfunction

  assign a_s    = num_a;
  assign b_s    = num_b;
  assign sd_s   = store_data;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;
  assign is_mul = (opcode == 5'b00000) && (aluop == 5'b00110);
  assign acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    br_take = 1'b0;
    case (opcode)
      5'b00000: begin
        case (aluop)
          5'b00000: begin alu_res = sum_s;  alu_ovf = add_ovf(a_s, b_s, sum_s);  end
          5'b00001: begin alu_res = diff_s; alu_ovf = sub_ovf(a_s, b_s, diff_s); end
          5'b00010: alu_res = num_a & num_b;
          5'b00011: alu_res = num_a | num_b;
          5'b00100: alu_res = num_a << shamt;
          5'b00101: alu_res = $unsigned(a_s >>> shamt);
          default:  alu_res = '0;
        endcase
      end
      5'b00101: begin alu_res = sum_s; alu_ovf = add_ovf(a_s, b_s, sum_s); end
      5'b00111, 5'b01000: alu_res = sum_s;
      5'b00010: br_take = (store_data != num_a);
      5'b00110: br_take = (sd_s < a_s);
      default: alu_res = '0;
    endcase
  end

  assign stall = ((state_q == IDLE) && in_valid && is_mul) ||
                 ((state_q == BUSY) && (count_q != LAST));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mrd_d    = mrd_q;
    men_d    = men_q;
    mmwen_d  = mmwen_q;
    mlw_d    = mlw_q;
    // Output register defaults to a bubble unless something retires this cycle
    valid_d  = 1'b0;
    result_d = '0;
    sdata_d  = '0;
    rd_d     = '0;
    en_d     = 1'b0;
    mwen_d   = 1'b0;
    lw_d     = 1'b0;
    ovf_d    = 1'b0;
    br_d     = 1'b0;
    tgt_d    = '0;
    case (state_q)
      IDLE: begin
        if (in_valid && is_mul) begin
          mcand_d  = num_a;
          mplier_d = num_b;
          acc_d    = '0;
          count_d  = '0;
          mrd_d    = rd;
          men_d    = en;
          mmwen_d  = mwen;
          mlw_d    = lw;
          state_d  = BUSY;
        end else if (in_valid) begin
          valid_d  = 1'b1;
          result_d = alu_res;
          sdata_d  = store_data;
          rd_d     = rd;
          en_d     = en;
          mwen_d   = mwen;
          lw_d     = lw;
          ovf_d    = alu_ovf;
          br_d     = br_take;
          tgt_d    = pc + 12'd1 + num_b[11:0];
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        if (count_q == LAST) begin
          state_d  = IDLE;
          count_d  = '0;
          valid_d  = 1'b1;
          result_d = acc_sum;
          rd_d     = mrd_q;
          en_d     = men_q;
          mwen_d   = mmwen_q;
          lw_d     = mlw_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mrd_q    <= '0;
      men_q    <= 1'b0;
      mmwen_q  <= 1'b0;
      mlw_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      sdata_q  <= '0;
      rd_q     <= '0;
      en_q     <= 1'b0;
      mwen_q   <= 1'b0;
      lw_q     <= 1'b0;
      ovf_q    <= 1'b0;
      br_q     <= 1'b0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mrd_q    <= mrd_d;
      men_q    <= men_d;
      mmwen_q  <= mmwen_d;
      mlw_q    <= mlw_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      sdata_q  <= sdata_d;
      rd_q     <= rd_d;
      en_q     <= en_d;
      mwen_q   <= mwen_d;
      lw_q     <= lw_d;
      ovf_q    <= ovf_d;
      br_q     <= br_d;
      tgt_q    <= tgt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = result_q;
  assign out_store_data = sdata_q;
  assign out_rd         = rd_q;
  assign out_en         = en_q;
  assign out_mwen       = mwen_q;
  assign out_lw         = lw_q;
  assign out_ovf        = ovf_q;
  assign branch_taken   = br_q;
  assign branch_target  = tgt_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU, branches, bubbles, multiplier timing
// and asynchronous reset during a multiply.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [11:0] pc;
  logic [4:0]  opcode, aluop, shamt, rd;
  logic [31:0] num_a, num_b, store_data;
  logic        en, mwen, lw;
  logic        stall, out_valid, out_en, out_mwen, out_lw, out_ovf, branch_taken;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic [11:0] branch_target;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .pc(pc),
    .opcode(opcode), .aluop(aluop), .shamt(shamt), .num_a(num_a),
    .num_b(num_b), .store_data(store_data), .rd(rd), .en(en),
    .mwen(mwen), .lw(lw), .stall(stall), .out_valid(out_valid),
    .out_result(out_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_en(out_en), .out_mwen(out_mwen),
    .out_lw(out_lw), .out_ovf(out_ovf), .branch_taken(branch_taken),
    .branch_target(branch_target)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] opc, input logic [4:0] aop,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sd, input logic [11:0] p,
                       input logic [4:0] r, input logic e, input logic mw,
                       input logic l, input logic [4:0] sh);
    in_valid = v; opcode = opc; aluop = aop; num_a = a; num_b = b;
    store_data = sd; pc = p; rd = r; en = e; mwen = mw; lw = l; shamt = sh;
    #1;
  endtask

  initial begin
    int n;
    int hi;
    logic seen;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_result", out_result, 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    step(); step();
    reset = 1'b1;

    // add overflow
    drive(1, 5'b00000, 5'b00000, 32'h7FFFFFFF, 32'd1, 32'd0, 12'd0, 5'd3, 1, 0, 0, 0);
    chk("add_stall", 32'(stall), 32'd0);
    step();
    chk("add_result", out_result, 32'h80000000);
    chk("add_ovf", 32'(out_ovf), 32'd1);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_valid", 32'(out_valid), 32'd1);

    // store address and data
    drive(1, 5'b00111, 5'b00000, 32'h100, 32'hFFFFFFFC, 32'hDEADBEEF, 12'd0, 5'd0, 0, 1, 0, 0);
    step();
    chk("sw_result", out_result, 32'hFC);
    chk("sw_mwen", 32'(out_mwen), 32'd1);
    chk("sw_sdata", out_store_data, 32'hDEADBEEF);
    chk("sw_ovf", 32'(out_ovf), 32'd0);

    drive(1, 5'b00000, 5'b00101, 32'h80000000, 32'd0, 32'd0, 12'd0, 5'd4, 1, 0, 0, 5'd4);
    step();
    chk("sra_result", out_result, 32'hF8000000);
    chk("sra_mwen", 32'(out_mwen), 32'd0);

    // branches
    drive(1, 5'b00110, 5'b00000, 32'd1, 32'd5, 32'hFFFFFFFF, 12'd10, 5'd0, 0, 0, 0, 0);
    step();
    chk("blt_taken", 32'(branch_taken), 32'd1);
    chk("blt_target", 32'(branch_target), 32'd16);
    chk("blt_result", out_result, 32'd0);
    drive(1, 5'b00010, 5'b00000, 32'd5, 32'd3, 32'd5, 12'd20, 5'd0, 0, 0, 0, 0);
    step();
    chk("bne_eq_taken", 32'(branch_taken), 32'd0);
    drive(1, 5'b00010, 5'b00000, 32'd2, 32'd0, 32'd1, 12'd4095, 5'd0, 0, 0, 0, 0);
    step();
    chk("bne_wrap_taken", 32'(branch_taken), 32'd1);
    chk("bne_wrap_target", 32'(branch_target), 32'd0);

    // bubble
    drive(0, 5'b00000, 5'b00000, 32'd9, 32'd9, 32'd9, 12'd0, 5'd7, 1, 1, 1, 0);
    step();
    chk("bub_valid", 32'(out_valid), 32'd0);
    chk("bub_en", 32'(out_en), 32'd0);
    chk("bub_mwen", 32'(out_mwen), 32'd0);
    chk("bub_taken", 32'(branch_taken), 32'd0);
    chk("bub_result", out_result, 32'd0);

    // multiply timing: 7 * -3
    drive(1, 5'b00000, 5'b00110, 32'd7, 32'hFFFFFFFD, 32'd0, 12'd0, 5'd9, 1, 0, 0, 0);
    hi = 0;
    seen = 1'b0;
    for (int k = 0; k < 33; k++) begin
      if (stall) hi++;
      if (k == 32) chk("mul_stall_last", 32'(stall), 32'd0);
      step();
      if (k < 32 && out_valid) seen = 1'b1;
    end
    chk("mul_stall_cycles", 32'(hi), 32'd32);
    chk("mul_busy_valid", 32'(seen), 32'd0);
    chk("mul_result", out_result, 32'hFFFFFFEB);
    chk("mul_valid", 32'(out_valid), 32'd1);
    chk("mul_rd", 32'(out_rd), 32'd9);
    chk("mul_en", 32'(out_en), 32'd1);
    chk("mul_ovf", 32'(out_ovf), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("mul_valid_once", 32'(out_valid), 32'd0);

    // back-to-back multiplies
    drive(1, 5'b00000, 5'b00110, 32'd3, 32'd4, 32'd0, 12'd0, 5'd1, 1, 0, 0, 0);
    n = 0;
    do begin step(); n++; end while (!out_valid && n < 40);
    chk("b2b1_edges", 32'(n), 32'd33);
    chk("b2b1_result", out_result, 32'd12);
    drive(1, 5'b00000, 5'b00110, 32'd5, 32'd6, 32'd0, 12'd0, 5'd2, 1, 0, 0, 0);
    n = 0;
    do begin step(); n++; end while (!out_valid && n < 40);
    chk("b2b2_edges", 32'(n), 32'd33);
    chk("b2b2_result", out_result, 32'd30);
    chk("b2b2_rd", 32'(out_rd), 32'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // asynchronous reset in the middle of a multiply
    drive(1, 5'b00000, 5'b00110, 32'd11, 32'd13, 32'd0, 12'd0, 5'd5, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) step();
    chk("rst_pre_stall", 32'(stall), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid || stall) seen = 1'b1;
    end
    chk("rst_no_result", 32'(seen), 32'd0);
    drive(1, 5'b00000, 5'b00000, 32'd1, 32'd1, 32'd0, 12'd0, 5'd4, 1, 0, 0, 0);
    step();
    chk("post_rst_add", out_result, 32'd2);
    chk("post_rst_valid", 32'(out_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
